// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: push handshake plus FIFO status.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (output wr_en, wr_data, input full, empty, count, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO; queued words go out back-to-back
// with configurable width, parity and stop bits.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rst_l,
  uart_tx_fifo_if.slave  wr,
  output logic           busy,
  output logic           done,
  output logic           tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned NW = $clog2(DATA_BITS);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: unsupported parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, empty_q, ovf_q;
  logic                 push_c, pop_c;
  logic [DATA_BITS-1:0] head_c;

  assign push_c  = wr.wr_en && !full_q;
  assign head_c  = mem[rd_ptr];
  assign count_d = count_q + CW'(push_c) - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr.wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
      if (wr.wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  assign wr.full     = full_q;
  assign wr.empty    = empty_q;
  assign wr.count    = count_q;
  assign wr.overflow = ovf_q;

  // Serialiser state
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [NW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_c, baud_last_c, stop_last_c;

  assign baud_last_c = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign stop_last_c = (stop_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last_c ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    pop_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty_q) load_c = 1'b1;
      end
      S_START: begin
        if (baud_last_c) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_last_c) begin
          if (bit_q == NW'(DATA_BITS - 1)) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + NW'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last_c) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        // done is registered, so raise it one cycle ahead of the final cycle
        if (stop_last_c && baud_q == BW'(CLKS_PER_BIT - 2)) done_d = 1'b1;
        if (baud_last_c) begin
          if (!stop_last_c) begin
            stop_d = 1'b1;
          end else if (!empty_q) begin
            load_c = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop the head word and open a new frame with its start bit
    if (load_c) begin
      pop_c   = 1'b1;
      shreg_d = head_c;
      par_d   = (^head_c) ^ (PARITY == 1);
      state_d = S_START;
      baud_d  = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five differently configured instances
// checked against hand-computed frame bit patterns.
module tb_uart_tx_fifo;

  localparam int unsigned C = 16;
  localparam int OVF_CNT [6] = '{1, 1, 2, 3, 4, 4};

  typedef struct {
    int          idx;
    int          nbits;
    logic [11:0] bits;      // frame as sent, bit 0 = start bit
    int          max_wait;
    string       name;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [4:0] wr_en_v;
  logic [7:0] data_v  [5];
  logic [4:0] count_v [5];
  logic [4:0] tx_v, busy_v, done_v, full_v, empty_v, ovf_v;

  int n_pass = 0;
  int n_total = 0;
  frame_t ft [14];

  always #5 clk = ~clk;

  // 0: 8N1 depth16  1: 8N1 depth4  2: 8E2  3: 8O2  4: 5N2
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus3 ();
  uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(16)) bus4 ();

  uart_tx_fifo #(.CLKS_PER_BIT(C)) u_dut0 (
    .clk(clk), .rst_l(rst_l), .wr(bus0), .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_l(rst_l), .wr(bus1), .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_l(rst_l), .wr(bus2), .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_l(rst_l), .wr(bus3), .busy(busy_v[3]), .done(done_v[3]), .tx(tx_v[3]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2)) u_dut4 (
    .clk(clk), .rst_l(rst_l), .wr(bus4), .busy(busy_v[4]), .done(done_v[4]), .tx(tx_v[4]));

  assign bus0.wr_en = wr_en_v[0];
  assign bus1.wr_en = wr_en_v[1];
  assign bus2.wr_en = wr_en_v[2];
  assign bus3.wr_en = wr_en_v[3];
  assign bus4.wr_en = wr_en_v[4];
  assign bus0.wr_data = data_v[0];
  assign bus1.wr_data = data_v[1];
  assign bus2.wr_data = data_v[2];
  assign bus3.wr_data = data_v[3];
  assign bus4.wr_data = data_v[4][4:0];

  assign count_v[0] = 5'(bus0.count);
  assign count_v[1] = 5'(bus1.count);
  assign count_v[2] = 5'(bus2.count);
  assign count_v[3] = 5'(bus3.count);
  assign count_v[4] = 5'(bus4.count);
  assign full_v  = {bus4.full, bus3.full, bus2.full, bus1.full, bus0.full};
  assign empty_v = {bus4.empty, bus3.empty, bus2.empty, bus1.empty, bus0.empty};
  assign ovf_v   = {bus4.overflow, bus3.overflow, bus2.overflow, bus1.overflow, bus0.overflow};

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check(act == exp, name, act, exp);
  endtask

  task automatic push_one(input int idx, input logic [7:0] d);
    wr_en_v[idx] = 1'b1;
    data_v[idx]  = d;
    @(negedge clk);
    wr_en_v[idx] = 1'b0;
  endtask

  task automatic push_words(input int idx, input logic [7:0] w [4], input int n);
    for (int i = 0; i < n; i++) begin
      wr_en_v[idx] = 1'b1;
      data_v[idx]  = w[i];
      @(negedge clk);
    end
    wr_en_v[idx] = 1'b0;
  endtask

  // Steps one cycle, allows max_wait more for the start bit, then checks
  // every cycle of every bit and that done is high on the final cycle only.
  task automatic expect_frame(input frame_t f);
    int          w;
    bit          bits_ok, done_ok, last;
    logic [11:0] got;
    @(negedge clk);
    w = 0;
    while (tx_v[f.idx] !== 1'b0 && w < f.max_wait) begin
      @(negedge clk);
      w++;
    end
    check_eq({f.name, " start"}, int'(tx_v[f.idx]), 0);
    if (tx_v[f.idx] !== 1'b0) return;
    bits_ok = 1'b1;
    done_ok = 1'b1;
    got     = '0;
    for (int b = 0; b < f.nbits; b++) begin
      for (int c = 0; c < int'(C); c++) begin
        last = (b == f.nbits - 1) && (c == int'(C) - 1);
        if (tx_v[f.idx] !== f.bits[b]) bits_ok = 1'b0;
        if (c == int'(C) / 2) got[b] = tx_v[f.idx];
        if (done_v[f.idx] !== last) done_ok = 1'b0;
        if (!last) @(negedge clk);
      end
    end
    check(bits_ok && got == f.bits, {f.name, " bits"}, int'(got), int'(f.bits));
    check(done_ok, {f.name, " done timing"}, int'(done_ok), 1);
  endtask

  task automatic idle_check(input int idx, input int n, input string name);
    bit ok = 1'b1;
    repeat (n) begin
      if (tx_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check(ok, name, int'(ok), 1);
  endtask

  initial begin
    ft[0]  = '{0, 10, 12'b00_1_00110001_0, 0, "single 0x31"};
    ft[1]  = '{0, 10, 12'b00_1_00000000_0, 1, "burst 0x00"};
    ft[2]  = '{0, 10, 12'b00_1_11111111_0, 0, "burst 0xFF"};
    ft[3]  = '{0, 10, 12'b00_1_01010101_0, 0, "burst 0x55"};
    ft[4]  = '{0, 10, 12'b00_1_10101010_0, 0, "burst 0xAA"};
    ft[5]  = '{1, 10, 12'b00_1_00000001_0, 1, "ovf 0x01"};
    ft[6]  = '{1, 10, 12'b00_1_00000010_0, 0, "ovf 0x02"};
    ft[7]  = '{1, 10, 12'b00_1_00000011_0, 0, "ovf 0x03"};
    ft[8]  = '{1, 10, 12'b00_1_00000100_0, 0, "ovf 0x04"};
    ft[9]  = '{1, 10, 12'b00_1_00000101_0, 0, "ovf 0x05"};
    ft[10] = '{2, 12, 12'b11_1_00000111_0, 0, "even 0x07"};
    ft[11] = '{3, 12, 12'b11_0_00000111_0, 0, "odd 0x07"};
    ft[12] = '{4, 8,  12'b0000_11_11111_0, 0, "narrow 0x1F"};
    ft[13] = '{4, 8,  12'b0000_11_01010_0, 0, "narrow 0xEA"};

    rst_l   = 1'b0;
    wr_en_v = '0;
    for (int i = 0; i < 5; i++) data_v[i] = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("reset status %0d", i),
               int'({tx_v[i], busy_v[i], done_v[i], full_v[i], empty_v[i], ovf_v[i]}),
               int'(6'b100010));
      check_eq($sformatf("reset count %0d", i), int'(count_v[i]), 0);
    end
    rst_l = 1'b1;
    @(negedge clk);

    // Single frame with exact push-to-start latency
    push_one(0, 8'h31);
    check_eq("single queued", int'({empty_v[0], tx_v[0], count_v[0]}), int'({1'b0, 1'b1, 5'd1}));
    expect_frame(ft[0]);
    @(negedge clk);
    check_eq("single after", int'({busy_v[0], tx_v[0], done_v[0]}), int'(3'b010));

    // Burst of four, frames back-to-back
    fork
      push_words(0, '{8'h00, 8'hFF, 8'h55, 8'hAA}, 4);
      for (int k = 1; k <= 4; k++) expect_frame(ft[k]);
    join
    check_eq("burst empty", int'(empty_v[0]), 1);
    @(negedge clk);
    check_eq("burst busy", int'(busy_v[0]), 0);

    // Six pushes into a depth-4 FIFO: the sixth is dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr_en_v[1] = 1'b1;
          data_v[1]  = 8'(i + 1);
          @(negedge clk);
          check_eq($sformatf("ovf count %0d", i), int'(count_v[1]), OVF_CNT[i]);
          check_eq($sformatf("ovf full %0d", i), int'(full_v[1]), int'(i >= 4));
          check_eq($sformatf("ovf flag %0d", i), int'(ovf_v[1]), int'(i == 5));
        end
        wr_en_v[1] = 1'b0;
      end
      for (int k = 5; k <= 9; k++) expect_frame(ft[k]);
    join
    @(negedge clk);
    idle_check(1, 3 * int'(C), "ovf no sixth frame");
    check_eq("ovf sticky", int'(ovf_v[1]), 1);

    // Parity modes and two stop bits
    push_one(2, 8'h07);
    expect_frame(ft[10]);
    push_one(3, 8'h07);
    expect_frame(ft[11]);

    // Five-bit payload; upper data bits must be ignored
    push_one(4, 8'h1F);
    expect_frame(ft[12]);
    @(negedge clk);
    push_one(4, 8'hEA);
    expect_frame(ft[13]);

    // Asynchronous reset in the middle of a data bit with words queued
    @(negedge clk);
    push_words(0, '{8'h00, 8'h00, 8'h00, 8'h00}, 3);
    repeat (3 * int'(C)) @(negedge clk);
    check_eq("pre-reset mid data", int'({tx_v[0], busy_v[0], count_v[0]}), int'({1'b0, 1'b1, 5'd2}));
    #2 rst_l = 1'b0;
    #1;
    check_eq("async reset tx", int'({tx_v[0], busy_v[0]}), int'(2'b10));
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check_eq("post-reset fifo", int'({empty_v[0], count_v[0]}), int'({1'b1, 5'd0}));
    idle_check(0, 3 * int'(C), "post-reset no frames");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
